// File: rtl/serial_cla_add_sub_if.sv
// Request/result bus for serial_cla_add_sub. Both ports use valid/ready: a transfer
// happens on a rising edge where valid && ready; the source holds its payload stable until then.
interface serial_cla_add_sub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, op_sub, a, b, cin, out_ready,
    input  in_ready, out_valid, result, cout, overflow
  );

  modport slave (
    input  in_valid, op_sub, a, b, cin, out_ready,
    output in_ready, out_valid, result, cout, overflow
  );
endinterface

// File: rtl/serial_cla_add_sub.sv
// Multi-cycle adder/subtractor: one SLICE-bit carry-lookahead slice is reused each cycle,
// with the carry (or inverted borrow) registered between slices.
module serial_cla_add_sub #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_cla_add_sub_if.slave  bus,
  output logic [1:0]           dbg_state
);
  localparam int NSL  = WIDTH / SLICE;
  localparam int IDXW = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] acc_r;
  logic             carry;
  logic             op_r;

  logic [SLICE-1:0] sl_g;
  logic [SLICE-1:0] sl_p;
  logic [SLICE:0]   sl_c;
  logic [SLICE-1:0] sl_sum;
  logic [WIDTH-1:0] next_acc;

  // Every carry is a flat sum-of-products of generate/propagate terms, not a ripple chain.
  function automatic logic [SLICE:0] cla_carries(input logic [SLICE-1:0] g,
                                                 input logic [SLICE-1:0] p,
                                                 input logic c0);
    logic [SLICE:0] c;
    logic           term;
    logic           sum_of_terms;
    c    = '0;
    c[0] = c0;
    for (int i = 1; i <= SLICE; i++) begin
      sum_of_terms = c0;
      for (int j = 0; j < i; j++) sum_of_terms = sum_of_terms & p[j];
      for (int k = 0; k < i; k++) begin
        term = g[k];
        for (int j = k + 1; j < i; j++) term = term & p[j];
        sum_of_terms = sum_of_terms | term;
      end
      c[i] = sum_of_terms;
    end
    return c;
  endfunction

  // Operands shift right each cycle, so the active slice always sits in the low bits.
  always_comb begin
    sl_g     = a_r[SLICE-1:0] & b_r[SLICE-1:0];
    sl_p     = a_r[SLICE-1:0] ^ b_r[SLICE-1:0];
    sl_c     = cla_carries(sl_g, sl_p, carry);
    sl_sum   = sl_p ^ sl_c[SLICE-1:0];
    next_acc = WIDTH'({sl_sum, acc_r} >> SLICE);
  end

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      a_r           <= '0;
      b_r           <= '0;
      acc_r         <= '0;
      carry         <= 1'b0;
      op_r          <= 1'b0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.cout      <= 1'b0;
      bus.overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            a_r          <= bus.a;
            b_r          <= bus.op_sub ? ~bus.b : bus.b;
            carry        <= bus.op_sub ? ~bus.cin : bus.cin;
            op_r         <= bus.op_sub;
            idx          <= '0;
            bus.in_ready <= 1'b0;
            state        <= CALC;
          end
        end
        CALC: begin
          a_r   <= a_r >> SLICE;
          b_r   <= b_r >> SLICE;
          acc_r <= next_acc;
          carry <= sl_c[SLICE];
          idx   <= idx + IDXW'(1);
          if (idx == LAST_IDX) begin
            // Low bits of a_r/b_r now hold the top slice, so their MSBs are the operand MSBs.
            bus.result    <= next_acc;
            bus.cout      <= op_r ? ~sl_c[SLICE] : sl_c[SLICE];
            bus.overflow  <= (a_r[SLICE-1] == b_r[SLICE-1]) && (sl_sum[SLICE-1] != a_r[SLICE-1]);
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state         <= IDLE;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_cla_add_sub.sv
// Bench for serial_cla_add_sub: directed corner operations with literal results, then
// randomized traffic compared every cycle against an arithmetic reference model.
module tb_serial_cla_add_sub;
  localparam int W   = 16;
  localparam int NSL = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  int         checks   = 0;
  int         failures = 0;
  bit         chk_en   = 1'b0;

  always #5 clk = ~clk;

  serial_cla_add_sub_if #(.WIDTH(W)) bus ();

  serial_cla_add_sub #(.WIDTH(W), .SLICE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Reference: {cout, overflow, result} from plain wide arithmetic.
  function automatic logic [W+1:0] ref_op(input logic op, input logic [W-1:0] ra,
                                          input logic [W-1:0] rb, input logic rc);
    logic [W:0] s;
    logic       ov;
    if (!op) begin
      s  = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      ov = (ra[W-1] == rb[W-1]) && (s[W-1] != ra[W-1]);
    end else begin
      s  = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rc};
      ov = (ra[W-1] != rb[W-1]) && (s[W-1] != ra[W-1]);
    end
    return {s[W], ov, s[W-1:0]};
  endfunction

  logic           m_ready = 1'b1;
  logic           m_valid = 1'b0;
  logic [W+1:0]   m_out   = '0;
  bit             m_busy  = 1'b0;
  int             m_cnt   = 0;
  logic [W+1:0]   exp_q[$];

  always @(posedge clk) begin
    if (rst) begin
      m_ready = 1'b1;
      m_valid = 1'b0;
      m_out   = '0;
      m_busy  = 1'b0;
      m_cnt   = 0;
      exp_q.delete();
    end else if (m_valid) begin
      if (bus.out_ready) begin
        m_valid = 1'b0;
        m_ready = 1'b1;
        void'(exp_q.pop_front());
      end
    end else if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_busy  = 1'b0;
        m_valid = 1'b1;
        m_out   = exp_q[0];
      end
    end else if (bus.in_valid) begin
      exp_q.push_back(ref_op(bus.op_sub, bus.a, bus.b, bus.cin));
      m_busy  = 1'b1;
      m_cnt   = NSL;
      m_ready = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready",  32'(bus.in_ready),  32'(m_ready));
      check("out_valid", 32'(bus.out_valid), 32'(m_valid));
      check("result",    32'(bus.result),    32'(m_out[W-1:0]));
      check("cout",      32'(bus.cout),      32'(m_out[W+1]));
      check("overflow",  32'(bus.overflow),  32'(m_out[W]));
    end
  end

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic send(input logic op, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                      input logic tc);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.op_sub   = op;
    bus.a        = ta;
    bus.b        = tb_v;
    bus.cin      = tc;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_lat"}, 32'(n), 32'(NSL));
  endtask

  task automatic run_dir(input string name, input logic op, input logic [W-1:0] ta,
                         input logic [W-1:0] tb_v, input logic tc, input logic [W-1:0] er,
                         input logic ec, input logic eo);
    int n;
    send(op, ta, tb_v, tc);
    wait_valid(name, n);
    check({name, "_res"},  32'(bus.result),   32'(er));
    check({name, "_cout"}, 32'(bus.cout),     32'(ec));
    check({name, "_ovf"},  32'(bus.overflow), 32'(eo));
    check({name, "_model"}, 32'(m_out), 32'({ec, eo, er}));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [W-1:0] corner[5];
    corner[0] = 16'h0000;
    corner[1] = 16'hFFFF;
    corner[2] = 16'h7FFF;
    corner[3] = 16'h8000;
    corner[4] = 16'h0001;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op_sub    = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    rst           = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result",    32'(bus.result),    32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_dir("add_b_6",    1'b0, 16'h000B, 16'h0006, 1'b0, 16'h0011, 1'b0, 1'b0);
    run_dir("add_ripple", 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_dir("add_ff_ff",  1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    run_dir("add_ovf",    1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_dir("sub_borrow", 1'b1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    run_dir("sub_ovf",    1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    run_dir("sub_bin",    1'b1, 16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0);

    // Back-pressure: result held while inputs churn, then exactly one handshake.
    send(1'b0, 16'h000B, 16'h0006, 1'b0);
    wait_valid("bp", n);
    repeat (3) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.a        = W'($urandom);
      bus.b        = W'($urandom);
      @(negedge clk);
      check("bp_hold_res",   32'(bus.result),   32'h0011);
      check("bp_hold_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp_rel_valid", 32'(bus.out_valid), 32'd0);
    check("bp_rel_ready", 32'(bus.in_ready),  32'd1);
    @(negedge clk);

    // Reset after two slice commits aborts the operation.
    send(1'b0, 16'hAAAA, 16'h5555, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_valid",  32'(bus.out_valid), 32'd0);
    check("abort_result", 32'(bus.result),    32'd0);
    check("abort_ready",  32'(bus.in_ready),  32'd1);
    run_dir("post_rst", 1'b0, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);

    // Random traffic: random valid, operands biased toward corners, back-pressure, rare resets.
    repeat (3000) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.op_sub    = 1'($urandom_range(0, 1));
      bus.a         = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
      bus.b         = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
      bus.cin       = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rst           = ($urandom_range(0, 399) == 0);
      @(negedge clk);
    end
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
